// File: rtl/key_conditioner.sv
// Synchronises and debounces active-low push-buttons; per key it emits a clean
// level plus single-cycle press, release and long-hold pulses.
//
// state        | meaning
// -------------+--------------------------------------------------------------
// IDLE         | key released and stable
// PRESS_WAIT   | key seen pressed, counting stable cycles before accepting
// PRESSED      | press accepted; hold counter running
// RELEASE_WAIT | key seen released, counting stable cycles; hold count frozen
module key_conditioner #(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000
) (
  input  logic              CLOCK_50,
  input  logic              RST,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_hold
);

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  localparam logic [19:0] DB_LAST   = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [25:0] HOLD_MAX  = 26'(HOLD_CYCLES);
  localparam bit          HOLD_EN   = (HOLD_CYCLES != 0);
  localparam logic [25:0] HOLD_LAST = HOLD_EN ? 26'(HOLD_CYCLES - 1) : 26'd0;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    logic [1:0]  sync_q;
    logic [1:0]  state_q,    state_d;
    logic [19:0] db_cnt_q,   db_cnt_d;
    logic [25:0] hold_cnt_q, hold_cnt_d;
    logic        level_q,    level_d;
    logic        press_q,    press_d;
    logic        release_q,  release_d;
    logic        hold_q,     hold_d;
    logic        s;

    assign s = sync_q[1];

    always_comb begin
      state_d    = state_q;
      db_cnt_d   = db_cnt_q;
      hold_cnt_d = hold_cnt_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      hold_d     = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (s) begin
            state_d  = ST_PRESS_WAIT;
            db_cnt_d = '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!s) begin
            state_d = ST_IDLE;
          end else if (db_cnt_q == DB_LAST) begin
            state_d = ST_PRESSED;
            press_d = 1'b1;
          end else begin
            db_cnt_d = db_cnt_q + 20'd1;
          end
        end
        ST_PRESSED: begin
          if (!s) begin
            state_d  = ST_RELEASE_WAIT;
            db_cnt_d = '0;
          end else begin
            // Saturation at HOLD_MAX is what keeps the hold pulse to one per press.
            if (hold_cnt_q != HOLD_MAX) hold_cnt_d = hold_cnt_q + 26'd1;
            if (HOLD_EN && (hold_cnt_q == HOLD_LAST)) hold_d = 1'b1;
          end
        end
        ST_RELEASE_WAIT: begin
          if (s) begin
            state_d = ST_PRESSED;
          end else if (db_cnt_q == DB_LAST) begin
            state_d    = ST_IDLE;
            release_d  = 1'b1;
            hold_cnt_d = '0;
          end else begin
            db_cnt_d = db_cnt_q + 20'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
    end

    always_ff @(posedge CLOCK_50) begin
      if (RST) begin
        sync_q     <= 2'b00;
        state_q    <= ST_IDLE;
        db_cnt_q   <= '0;
        hold_cnt_q <= '0;
        level_q    <= 1'b0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        hold_q     <= 1'b0;
      end else begin
        sync_q     <= {sync_q[0], ~KEY[i]};
        state_q    <= state_d;
        db_cnt_q   <= db_cnt_d;
        hold_cnt_q <= hold_cnt_d;
        level_q    <= level_d;
        press_q    <= press_d;
        release_q  <= release_d;
        hold_q     <= hold_d;
      end
    end

    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
    assign key_hold[i]    = hold_q;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: run-length reference model checked every cycle on
// two instances (hold enabled / hold disabled) plus hand-timed directed checks.
module tb_key_conditioner;

  localparam int DB = 4;
  localparam int HC = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key;
  logic [1:0] lv_a, pr_a, rl_a, hd_a;
  logic [1:0] lv_b, pr_b, rl_b, hd_b;

  key_conditioner #(.N_KEYS(2), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HC)) dut (
    .CLOCK_50(clk), .RST(rst), .KEY(key),
    .key_level(lv_a), .key_press(pr_a), .key_release(rl_a), .key_hold(hd_a)
  );

  key_conditioner #(.N_KEYS(2), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(0)) dut_nh (
    .CLOCK_50(clk), .RST(rst), .KEY(key),
    .key_level(lv_b), .key_press(pr_b), .key_release(rl_b), .key_hold(hd_b)
  );

  always #5 clk = ~clk;

  // Model: a change is accepted once the synchronised input has disagreed with
  // the debounced level for DB+1 consecutive samples; hold fires once per press
  // after HOLD steadily-pressed samples.
  int         run   [2][2];
  int         hcnt  [2][2];
  bit         fired [2][2];
  bit         h0    [2][2];
  bit         h1    [2][2];
  logic [1:0] ml [2];
  logic [1:0] mp [2];
  logic [1:0] mr [2];
  logic [1:0] mh [2];

  always @(posedge clk) begin
    bit s;
    int hp;
    for (int u = 0; u < 2; u++) begin
      hp = (u == 0) ? HC : 0;
      for (int c = 0; c < 2; c++) begin
        if (rst) begin
          h0[u][c] = 0; h1[u][c] = 0; run[u][c] = 0; hcnt[u][c] = 0; fired[u][c] = 0;
          ml[u][c] = 0; mp[u][c] = 0; mr[u][c] = 0; mh[u][c] = 0;
        end else begin
          s = h1[u][c];
          h1[u][c] = h0[u][c];
          h0[u][c] = ~key[c];
          mp[u][c] = 0; mr[u][c] = 0; mh[u][c] = 0;
          if (s != ml[u][c]) begin
            run[u][c]++;
            if (run[u][c] == DB + 1) begin
              ml[u][c]  = s;
              run[u][c] = 0;
              if (s) mp[u][c] = 1;
              else begin
                mr[u][c] = 1; hcnt[u][c] = 0; fired[u][c] = 0;
              end
            end
          end else begin
            if (ml[u][c] && run[u][c] == 0) begin
              hcnt[u][c]++;
              if (hp > 0 && hcnt[u][c] == hp && !fired[u][c]) begin
                mh[u][c] = 1; fired[u][c] = 1;
              end
            end
            run[u][c] = 0;
          end
        end
      end
    end
  end

  int n_vec = 0;
  int n_bad = 0;
  int cnt_p [2][2];
  int cnt_r [2][2];
  int cnt_h [2][2];

  task automatic check_inst(input int u, input logic [1:0] lv, input logic [1:0] pr,
                            input logic [1:0] rl, input logic [1:0] hd);
    n_vec++;
    if ({lv, pr, rl, hd} !== {ml[u], mp[u], mr[u], mh[u]}) begin
      n_bad++;
      $display("FAIL cycle_cmp inst%0d t=%0t: got lvl=%b prs=%b rel=%b hld=%b want lvl=%b prs=%b rel=%b hld=%b",
               u, $time, lv, pr, rl, hd, ml[u], mp[u], mr[u], mh[u]);
    end
    for (int c = 0; c < 2; c++) begin
      if (pr[c] === 1'b1) cnt_p[u][c]++;
      if (rl[c] === 1'b1) cnt_r[u][c]++;
      if (hd[c] === 1'b1) cnt_h[u][c]++;
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_inst(0, lv_a, pr_a, rl_a, hd_a);
      check_inst(1, lv_b, pr_b, rl_b, hd_b);
    end
  endtask

  task automatic lit(input string nm, input logic [1:0] got, input logic [1:0] mdl,
                     input logic [1:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, got, want);
    end
    if (mdl !== want) begin
      n_bad++;
      $display("FAIL %s (model): got %b want %b", nm, mdl, want);
    end
  endtask

  task automatic cnt_chk(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  int base0, base1, base2;

  initial begin
    for (int u = 0; u < 2; u++)
      for (int c = 0; c < 2; c++) begin
        cnt_p[u][c] = 0; cnt_r[u][c] = 0; cnt_h[u][c] = 0;
      end
    rst = 1'b1;
    key = 2'b11;
    step(3);
    lit("reset_level", lv_a, ml[0], 2'b00);
    lit("reset_pulses", pr_a | rl_a | hd_a, mp[0] | mr[0] | mh[0], 2'b00);
    rst = 1'b0;
    step(3);

    // clean press on key 0
    key = 2'b10;
    step(6);
    lit("press_e5", pr_a, mp[0], 2'b00);
    lit("level_e5", lv_a, ml[0], 2'b00);
    step(1);
    lit("press_e6", pr_a, mp[0], 2'b01);
    lit("level_e6", lv_a, ml[0], 2'b01);
    step(1);
    lit("press_e7", pr_a, mp[0], 2'b00);
    step(8);
    lit("hold_e15", hd_a, mh[0], 2'b00);
    step(1);
    lit("hold_e16", hd_a, mh[0], 2'b01);
    base0 = cnt_h[0][0];
    step(30);
    cnt_chk("hold_refire", cnt_h[0][0] - base0, 0);

    // release with a one-sample glitch
    base0 = cnt_r[0][0];
    key = 2'b11; step(2);
    key = 2'b10; step(1);
    key = 2'b11;
    step(6);
    lit("release_e5", rl_a, mr[0], 2'b00);
    lit("rel_level_e5", lv_a, ml[0], 2'b01);
    step(1);
    lit("release_e6", rl_a, mr[0], 2'b01);
    lit("rel_level_e6", lv_a, ml[0], 2'b00);
    step(5);
    cnt_chk("release_count", cnt_r[0][0] - base0, 1);

    // press bounce
    step(4);
    base0 = cnt_p[0][0];
    key = 2'b10; step(3);
    key = 2'b11; step(1);
    key = 2'b10;
    step(6);
    lit("bounce_press_e5", pr_a, mp[0], 2'b00);
    step(1);
    lit("bounce_press_e6", pr_a, mp[0], 2'b01);
    step(5);
    cnt_chk("bounce_press_count", cnt_p[0][0] - base0, 1);
    key = 2'b11;
    step(12);

    // both keys on the same edge
    key = 2'b00;
    step(6);
    lit("both_press_e5", pr_a, mp[0], 2'b00);
    step(1);
    lit("both_press_e6", pr_a, mp[0], 2'b11);
    lit("both_level_e6", lv_a, ml[0], 2'b11);
    step(1);
    lit("both_press_e7", pr_a, mp[0], 2'b00);
    key = 2'b11;
    step(12);

    // reset in PRESS_WAIT, then in PRESSED, key held throughout
    key = 2'b10;
    step(4);
    rst = 1'b1; step(1);
    lit("rst1_level", lv_a, ml[0], 2'b00);
    rst = 1'b0;
    step(6);
    lit("rst1_press_e10", pr_a, mp[0], 2'b00);
    step(1);
    lit("rst1_press_e11", pr_a, mp[0], 2'b01);
    rst = 1'b1; step(1);
    lit("rst2_level", lv_a, ml[0], 2'b00);
    lit("rst2_pulses", pr_a | hd_a, mp[0] | mh[0], 2'b00);
    rst = 1'b0;
    step(6);
    lit("rst2_press_e18", pr_a, mp[0], 2'b00);
    step(1);
    lit("rst2_press_e19", pr_a, mp[0], 2'b01);
    lit("rst2_level_e19", lv_a, ml[0], 2'b01);

    // long hold on key 1 with hold disabled on the second instance
    base0 = cnt_h[1][1];
    base1 = cnt_h[0][1];
    base2 = cnt_p[1][1];
    key = 2'b01;
    step(100);
    cnt_chk("nohold_hold_count", cnt_h[1][1] - base0, 0);
    cnt_chk("hold_on_count", cnt_h[0][1] - base1, 1);
    cnt_chk("nohold_press_count", cnt_p[1][1] - base2, 1);
    key = 2'b11;
    step(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Input conditioning stage that sits directly upstream of the stopwatch timer on the DE10-Standard. It takes the raw, active-low, bouncing `KEY` push-buttons and synchronises and debounces each one. For each key it produces a clean level plus single-cycle press, release and long-hold pulses. The timer consumes the pulses for start/pause toggle and clear, so one physical press yields exactly one action.

## Interface

- `N_KEYS`, 2: number of independent key channels.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles required to accept a change (20 ms at 50 MHz). Legal range 1 to 2^20−1.
- `HOLD_CYCLES`, 50_000_000: cycles in `PRESSED` before `key_hold` fires (1 s). 0 disables hold. Legal range 0 to 2^26−1.

Ports:

- `CLOCK_50`  input  1  single clock, 50 MHz. All logic is on the rising edge.
- `RST`  input  1  reset, synchronous and active-high.
- `KEY`  input  N_KEYS  raw buttons, active-low (0 = pressed), asynchronous to `CLOCK_50`.
- `key_level`  output  N_KEYS  debounced state, active-high (1 = pressed).
- `key_press`  output  N_KEYS  one-cycle pulse on each accepted press.
- `key_release`  output  N_KEYS  one-cycle pulse on each accepted release.
- `key_hold`  output  N_KEYS  one-cycle pulse, at most once per press, after `HOLD_CYCLES` held.

## Operation

- Each channel is fully independent: its own synchroniser, FSM, 20-bit debounce counter and 26-bit hold counter.
- Synchroniser: two flops on `~KEY[i]`. The output `s` is the synchronised pressed flag. Both flops reset to 0 (released).
- FSM states and transitions:
  - IDLE: if `s=1`, go to PRESS_WAIT and clear the debounce counter.
  - PRESS_WAIT:
    - `s=0`: return to IDLE with no pulse (bounce rejected).
    - `s=1` and counter = DEBOUNCE_CYCLES−1: go to PRESSED and register `key_press=1`.
    - Otherwise: increment the counter.
  - PRESSED:
    - `s=0`: go to RELEASE_WAIT and clear the debounce counter.
    - Otherwise, the hold counter increments. It saturates at HOLD_CYCLES.
    - When the hold counter reaches HOLD_CYCLES−1 while in PRESSED and HOLD_CYCLES≠0: register `key_hold=1`.
  - RELEASE_WAIT:
    - `s=1`: return to PRESSED with no pulse. The hold counter is kept and frozen while in this state.
    - `s=0` and counter = DEBOUNCE_CYCLES−1: go to IDLE, register `key_release=1`, clear the hold counter.
    - Otherwise: increment the counter.
- `key_level[i]` = 1 exactly when the FSM is in PRESSED or RELEASE_WAIT. It is registered.
- `key_hold` fires at most once per press. The saturated hold counter prevents a re-fire, including after returning from RELEASE_WAIT.
- Counters never wrap. The debounce counter is bounded by the compare and is cleared on every state entry. The hold counter saturates.

## Timing

- All outputs are registered. Reset values: `key_level`=0, `key_press`=0, `key_release`=0, `key_hold`=0. All FSMs are in IDLE, all counters are 0, and the synchronisers are 0.
- Latency, with edge 0 being the first edge sampling `KEY[i]`=0 and the key held stable:
  - the FSM enters PRESS_WAIT at edge 2;
  - `key_press` and `key_level` rise at edge 2+DEBOUNCE_CYCLES;
  - `key_press` is high for exactly one cycle.
- Release latency is symmetrical: `key_release` pulses and `key_level` falls at edge 2+DEBOUNCE_CYCLES after the first edge sampling `KEY[i]`=1.
- Hold: `key_hold` pulses HOLD_CYCLES edges after `key_press` rose, provided the FSM stays in PRESSED throughout.
- Pulse exclusivity:
  - `key_press` and `key_release` are never high together on one channel.
  - `key_hold` cannot coincide with `key_press`, except when HOLD_CYCLES=1, in which case it fires one cycle after `key_press`.
- Simultaneous events on different channels are processed independently in the same cycle.
- `RST` asserted mid-operation:
  - at the next edge, all state returns to reset values and any pending pulse is dropped;
  - if a key is still held when `RST` falls, it is re-debounced from IDLE and produces a fresh `key_press`.

## Test plan

Simulation parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, N_KEYS=2.

- Clean press on KEY[0] at edge 0, held stable:
  - `key_press[0]` is high for the single cycle after edge 6;
  - `key_level[0]`=1 from edge 6;
  - `key_hold[0]` pulses once after edge 16 and never again while held.
- Bounce: KEY[0] low for 3 cycles, high for 1, then low and stable:
  - no pulse from the first burst;
  - exactly one `key_press[0]`, timed 6 edges after the final falling sample.
- Release bounce: from PRESSED, KEY[0] goes high for 2 cycles, low for 1, then high and stable:
  - `key_level[0]` stays 1 through the glitch;
  - exactly one `key_release[0]` pulse, 6 edges after the final rising sample.
- Both keys pressed on the same edge: `key_press`=2'b11 in the same single cycle.
- Reset mid-debounce and mid-hold: assert `RST` for 1 cycle at edge 4 after a press (PRESS_WAIT), and again at edge 12 (PRESSED):
  - outputs go to 0 at the next edge;
  - with the key still held, `key_press` fires 6 edges after `RST` drops.
- HOLD_CYCLES=0: hold the key for 100 cycles; `key_hold` stays 0.
